// File: rtl/logic_gate_pipe.sv
// Registered two-operand bitwise gate unit with a DEPTH-entry output FIFO and
// valid/ready handshakes on both sides; each stored result carries zero/ones flags.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [2:0]                   op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             y,
    output logic                         y_zero,
    output logic                         y_ones,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_y    [DEPTH];
    logic             mem_zero [DEPTH];
    logic             mem_ones [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] result;

    always_comb begin
        result = a;
        case (op)
            3'd0:    result = a & b;
            3'd1:    result = a | b;
            3'd2:    result = a ^ b;
            3'd3:    result = ~(a & b);
            3'd4:    result = ~(a | b);
            3'd5:    result = ~(a ^ b);
            3'd6:    result = a & ~b;
            default: result = a;
        endcase
    end

    // Ready depends only on the registered count, so a pop frees the slot one cycle later.
    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is left uncleared on reset; the empty-state output gating hides it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_y[wr_ptr]    <= result;
            mem_zero[wr_ptr] <= (result == '0);
            mem_ones[wr_ptr] <= (result == '1);
        end
    end

    assign y      = out_valid ? mem_y[rd_ptr]    : '0;
    assign y_zero = out_valid ? mem_zero[rd_ptr] : 1'b0;
    assign y_ones = out_valid ? mem_ones[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe: truth-table vectors, flags, back-pressure,
// async reset, randomized traffic against a per-bit truth-table model, and a WIDTH=1 instance.
module tb_logic_gate_pipe;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] ey;
        logic       ez;
        logic       eo;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        logic       z;
        logic       o;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, y_zero, y_ones;
    logic [7:0] a, b, y;
    logic [2:0] op;
    logic [1:0] count;

    logic       in_valid1, in_ready1, out_valid1, out_ready1, y_zero1, y_ones1;
    logic [0:0] a1, b1, y1;
    logic [2:0] op1;
    logic [2:0] count1;

    int tests_run = 0;
    int tests_failed = 0;

    // Per-op truth table, bit k is the result for the input pair {a_i,b_i} == k.
    logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                           4'b0001, 4'b1001, 4'b0100, 4'b1100};

    res_t q[$];

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(8), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_zero(y_zero), .y_ones(y_ones), .count(count)
    );

    logic_gate_pipe #(.WIDTH(1), .DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .op(op1), .out_valid(out_valid1), .out_ready(out_ready1),
        .y(y1), .y_zero(y_zero1), .y_ones(y_ones1), .count(count1)
    );

    function automatic logic [63:0] ref_gate(input logic [63:0] x, input logic [63:0] z,
                                             input logic [2:0] f, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = tt[f][{x[i], z[i]}];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One model-checked cycle of the 8-bit instance: compare, then advance DUT and model together.
    task automatic applyStimulus(input string tag);
        logic push, pop;
        res_t r;
        int   n;
        n = q.size();
        checkOutput({tag, " in_ready"},  64'(in_ready),  64'(n < 2));
        checkOutput({tag, " out_valid"}, 64'(out_valid), 64'(n != 0));
        checkOutput({tag, " count"},     64'(count),     64'(n));
        checkOutput({tag, " y"},         64'(y),         (n != 0) ? 64'(q[0].y) : 64'd0);
        checkOutput({tag, " y_zero"},    64'(y_zero),    (n != 0) ? 64'(q[0].z) : 64'd0);
        checkOutput({tag, " y_ones"},    64'(y_ones),    (n != 0) ? 64'(q[0].o) : 64'd0);
        push = in_valid && (n < 2);
        pop  = out_ready && (n > 0);
        r.y = 8'(ref_gate(64'(a), 64'(b), op, 8));
        r.z = (r.y == 8'h00);
        r.o = (r.y == 8'hFF);
        @(posedge clk); #1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(r);
    endtask

    initial begin
        vec_t vecs [10];
        logic [0:0] va1 [4];
        logic [0:0] vb1 [4];
        logic [2:0] vop1 [4];
        logic [7:0] e;
        int pushed, cyc, guard;
        logic acc;

        vecs[0] = '{8'hCA, 8'hAC, 3'd0, 8'h88, 1'b0, 1'b0};
        vecs[1] = '{8'hCA, 8'hAC, 3'd1, 8'hEE, 1'b0, 1'b0};
        vecs[2] = '{8'hCA, 8'hAC, 3'd2, 8'h66, 1'b0, 1'b0};
        vecs[3] = '{8'hCA, 8'hAC, 3'd3, 8'h77, 1'b0, 1'b0};
        vecs[4] = '{8'hCA, 8'hAC, 3'd4, 8'h11, 1'b0, 1'b0};
        vecs[5] = '{8'hCA, 8'hAC, 3'd5, 8'h99, 1'b0, 1'b0};
        vecs[6] = '{8'hCA, 8'hAC, 3'd6, 8'h42, 1'b0, 1'b0};
        vecs[7] = '{8'hCA, 8'hAC, 3'd7, 8'hCA, 1'b0, 1'b0};
        vecs[8] = '{8'hFF, 8'hFF, 3'd0, 8'hFF, 1'b0, 1'b1};
        vecs[9] = '{8'hFF, 8'hFF, 3'd2, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; a = 0; b = 0; op = 0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; op1 = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready",  64'(in_ready),  64'd1);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset y",         64'(y),         64'd0);
        checkOutput("reset count",     64'(count),     64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle out_valid", 64'(out_valid), 64'd0);

        // Back-to-back truth table with out_ready held high.
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; in_valid = 1;
            @(posedge clk); #1;
            checkOutput($sformatf("tt%0d out_valid", i), 64'(out_valid), 64'd1);
            checkOutput($sformatf("tt%0d y", i),         64'(y),         64'(vecs[i].ey));
            checkOutput($sformatf("tt%0d y_zero", i),    64'(y_zero),    64'(vecs[i].ez));
            checkOutput($sformatf("tt%0d y_ones", i),    64'(y_ones),    64'(vecs[i].eo));
            checkOutput($sformatf("tt%0d count", i),     64'(count),     64'd1);
        end
        in_valid = 0;
        @(posedge clk); #1;
        checkOutput("tt drain out_valid", 64'(out_valid), 64'd0);
        checkOutput("tt drain y",         64'(y),         64'd0);

        // Full and back-pressure.
        out_ready = 0; in_valid = 1;
        a = 8'h11; b = 8'h22; op = 3'd1;
        @(posedge clk); #1;
        checkOutput("full c1 count", 64'(count), 64'd1);
        a = 8'hF0; b = 8'h3C; op = 3'd2;
        @(posedge clk); #1;
        checkOutput("full c2 count",    64'(count),    64'd2);
        checkOutput("full c2 in_ready", 64'(in_ready), 64'd0);
        a = 8'h5A; b = 8'h0F; op = 3'd0;
        @(posedge clk); #1;
        checkOutput("full held count", 64'(count), 64'd2);
        checkOutput("full held y",     64'(y),     64'h33);
        out_ready = 1;
        @(posedge clk); #1;
        checkOutput("full pop1 y",        64'(y),        64'hCC);
        checkOutput("full pop1 count",    64'(count),    64'd1);
        checkOutput("full pop1 in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 0;
        checkOutput("full pop2 y",     64'(y),     64'h0A);
        checkOutput("full pop2 count", 64'(count), 64'd1);
        @(posedge clk); #1;
        checkOutput("full empty count", 64'(count), 64'd0);

        // Async reset with two entries stored.
        out_ready = 0; in_valid = 1; a = 8'h0F; b = 8'h0F; op = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 0;
        checkOutput("mid count before reset", 64'(count), 64'd2);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("mid reset in_ready",  64'(in_ready),  64'd1);
        checkOutput("mid reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid reset y",         64'(y),         64'd0);
        checkOutput("mid reset count",     64'(count),     64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post reset out_valid", 64'(out_valid), 64'd0);

        // Randomized traffic against the queue model.
        q.delete();
        pushed = 0; cyc = 0; in_valid = 0;
        while (pushed < 20 && cyc < 300) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1;
                a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            acc = in_valid && (q.size() < 2);
            applyStimulus("rand");
            if (acc) begin
                pushed++;
                in_valid = 0;
            end
            cyc++;
        end
        in_valid = 0;
        checkOutput("rand pushes done", 64'(pushed), 64'd20);
        out_ready = 1; guard = 0;
        while (q.size() > 0 && guard < 10) begin
            applyStimulus("drain");
            guard++;
        end
        checkOutput("rand drained out_valid", 64'(out_valid), 64'd0);

        // WIDTH=1, DEPTH=4 instance: fill, ignore when full, drain in order.
        va1 = '{1'b1, 1'b1, 1'b0, 1'b1};
        vb1 = '{1'b0, 1'b1, 1'b0, 1'b0};
        vop1 = '{3'd6, 3'd3, 3'd4, 3'd0};
        out_ready1 = 0;
        for (int i = 0; i < 4; i++) begin
            a1 = va1[i]; b1 = vb1[i]; op1 = vop1[i]; in_valid1 = 1;
            @(posedge clk); #1;
        end
        checkOutput("w1 count full", 64'(count1),    64'd4);
        checkOutput("w1 in_ready",   64'(in_ready1), 64'd0);
        checkOutput("w1 y head",     64'(y1),        64'd1);
        checkOutput("w1 y_ones",     64'(y_ones1),   64'd1);
        checkOutput("w1 y_zero",     64'(y_zero1),   64'd0);
        a1 = 0; b1 = 0; op1 = 3'd7;
        @(posedge clk); #1;
        checkOutput("w1 full ignored", 64'(count1), 64'd4);
        in_valid1 = 0; out_ready1 = 1;
        for (int i = 0; i < 4; i++) begin
            e = 8'(ref_gate(64'(va1[i]), 64'(vb1[i]), vop1[i], 1));
            checkOutput($sformatf("w1 drain%0d y", i),      64'(y1),      64'(e));
            checkOutput($sformatf("w1 drain%0d y_zero", i), 64'(y_zero1), 64'(e == 8'd0));
            checkOutput($sformatf("w1 drain%0d y_ones", i), 64'(y_ones1), 64'(e == 8'd1));
            @(posedge clk); #1;
        end
        checkOutput("w1 empty out_valid", 64'(out_valid1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
# logic_gate_pipe

Parametrised, registered two-operand bitwise gate unit: the pipelined successor to the single-bit combinational AND gate. Applies one of eight selectable gate functions to two WIDTH-bit operands, buffers results in a DEPTH-entry output FIFO, and exchanges data over valid/ready handshakes on both sides. It also produces per-result reduction flags. It is the standard gate primitive for datapaths that need back-pressure.

## Interface
- WIDTH, 8, operand/result width in bits (1..64)
- DEPTH, 2, output FIFO entries; power of two, 2..16
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op are valid
- in_ready  out  1  block can accept; equals (count < DEPTH)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  gate select, sampled with operands
- out_valid  out  1  FIFO head holds a result; equals (count != 0)
- out_ready  in  1  consumer accepts head
- y  out  WIDTH  head result; 0 when out_valid=0
- y_zero  out  1  head result is all zeros; 0 when out_valid=0
- y_ones  out  1  head result is all ones; 0 when out_valid=0
- count  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- Gate select op:
  - 0 AND
  - 1 OR
  - 2 XOR
  - 3 NAND
  - 4 NOR
  - 5 XNOR
  - 6 a & ~b
  - 7 pass a
- All functions are bitwise over WIDTH bits. There is no carry or cross-bit interaction.
- Push: in_valid & in_ready at a clk edge. The computed result f(a,b,op) and its flags are written at the write pointer. wr_ptr increments, wrapping modulo DEPTH.
- Pop: out_valid & out_ready at a clk edge. rd_ptr increments, wrapping modulo DEPTH.
- Occupancy:
  - count += push, count -= pop.
  - Push and pop in the same edge leaves count unchanged.
- Full (count=DEPTH):
  - in_ready=0. in_valid is ignored; nothing is written and no stored entry changes.
  - A simultaneous pop frees a slot. in_ready rises the following cycle; there is no combinational ready pass-through.
- Empty (count=0):
  - out_valid=0. out_ready is ignored; pointers do not move.
  - y, y_zero and y_ones are forced to 0.
- Ordering: strict FIFO. Results emerge in acceptance order.
- y_zero and y_ones are computed on the result before storage. With WIDTH=1, both describe the single bit.
- Reset (async assert, rst_n low), applied immediately, including mid-transfer:
  - count=0, wr_ptr=rd_ptr=0
  - out_valid=0, in_ready=1
  - y=0, y_zero=0, y_ones=0
  - Stored entries are discarded. Memory contents need not be cleared but are never visible.
- Reset deassertion: the first push is possible at the first clk edge with rst_n high.

## Timing
- Latency: an operand accepted at edge N produces out_valid=1 with its result on y after edge N, provided the FIFO is empty. Minimum latency is one cycle.
- Throughput: one result per cycle sustained when out_ready is held high.
- in_ready, out_valid, count, y and the flags are all driven from registers or from FIFO storage addressed by a register. No input-to-output combinational path exists.
- Stability:
  - y and the flags stay stable while out_valid=1 and out_ready=0.
  - Upstream must hold a, b and op stable while in_valid=1 and in_ready=0.
- Changes to op while in_valid=0 have no effect.

## Test plan
- Reset and idle:
  - Assert rst_n=0 mid-stream with count=2: in_ready=1, out_valid=0, y=0 and count=0 immediately, before any clk edge.
  - After release, out_valid stays 0 with in_valid=0.
- Truth table (WIDTH=8), a=8'hCA, b=8'hAC, op=0..7 pushed back-to-back with out_ready=1:
  - y = 88, EE, 66, 77, 11, 99, 42, CA on consecutive cycles
  - Each result appears one cycle after its push
  - y_zero=0 and y_ones=0 for all eight
- Flags:
  - a=8'hFF, b=8'hFF, op=0: y=FF, y_ones=1, y_zero=0
  - op=2 with the same operands: y=00, y_zero=1, y_ones=0
- Full and back-pressure (DEPTH=2):
  - out_ready=0, push three operations: the first two are accepted, then in_ready=0 and count=2. The third is held.
  - Raise out_ready: the results drain in order, and the held third is accepted one cycle after the first pop.
- Simultaneous push and pop at count=1: count stays 1, pointers wrap past DEPTH-1 correctly, and 20 random operations match a bitwise reference model in order.
- Parametric: rerun the truth-table and full tests at WIDTH=1, DEPTH=4 and at WIDTH=32, DEPTH=16. At WIDTH=1 with a=1, b=0, op=6: y=1, y_ones=1.
